// File: rtl/cla8_pkg.sv
// Shared types and constants for the 8-bit saturating carry-lookahead adder.
package cla8_pkg;

    typedef logic signed [7:0] s8_t;

    localparam s8_t S8_MAX  = 8'sh7F;
    localparam s8_t S8_MIN  = 8'sh80;
    localparam int  CLA_GRP = 4;

endpackage

// File: rtl/cla8_sat_out_cla4_group.sv
// 4-bit carry-lookahead group: flattened carries, raw sum, and group generate/propagate.
module cla4_group
    import cla8_pkg::*;
(
    input  logic [CLA_GRP-1:0] a,
    input  logic [CLA_GRP-1:0] b,
    input  logic               cin,
    output logic [CLA_GRP-1:0] sum,
    output logic               grp_gen,
    output logic               grp_prop
);

    logic [CLA_GRP-1:0] g;
    logic [CLA_GRP-1:0] p;
    logic [CLA_GRP-1:0] c;

    // Every carry is a two-level sum of products, so no carry waits on its neighbour.
    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);

        grp_gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
        grp_prop = &p;

        sum = p ^ c;
    end

endmodule

// File: rtl/cla8_sat_out.sv
// Registered 8-bit signed saturating adder on two 4-bit lookahead groups.
// Define CLA8_IN_REG_EN to register the operands first (2-cycle latency).
module cla8_sat_out
    import cla8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  s8_t         a,
    input  s8_t         b,
    output s8_t         sum,
    output logic        ovf,
    output logic        uvf
);

    s8_t  op_a;
    s8_t  op_b;
    s8_t  raw;
    logic lo_gen;
    logic unused_lo_prop;
    logic unused_hi_gen;
    logic unused_hi_prop;

    s8_t  sum_d, sum_q;
    logic ovf_d, ovf_q;
    logic uvf_d, uvf_q;

`ifdef CLA8_IN_REG_EN
    s8_t  a_d, a_q;
    s8_t  b_d, b_q;

    always_comb begin
        a_d = a;
        b_d = b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign op_a = a_q;
    assign op_b = b_q;
`else
    assign op_a = a;
    assign op_b = b;
`endif

    // Carry-in is zero, so the low group's generate is the carry into the high group.
    cla4_group u_lo (
        .a        (op_a[3:0]),
        .b        (op_b[3:0]),
        .cin      (1'b0),
        .sum      (raw[3:0]),
        .grp_gen  (lo_gen),
        .grp_prop (unused_lo_prop)
    );

    cla4_group u_hi (
        .a        (op_a[7:4]),
        .b        (op_b[7:4]),
        .cin      (lo_gen),
        .sum      (raw[7:4]),
        .grp_gen  (unused_hi_gen),
        .grp_prop (unused_hi_prop)
    );

    // Overflow is only possible when both operands share a sign the raw result lost.
    always_comb begin
        sum_d = raw;
        ovf_d = 1'b0;
        uvf_d = 1'b0;
        if (!op_a[7] && !op_b[7] && raw[7]) begin
            sum_d = S8_MAX;
            ovf_d = 1'b1;
        end else if (op_a[7] && op_b[7] && !raw[7]) begin
            sum_d = S8_MIN;
            uvf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
            uvf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
            uvf_q <= uvf_d;
        end
    end

    assign sum = sum_q;
    assign ovf = ovf_q;
    assign uvf = uvf_q;

endmodule

// File: tb/tb_cla8_sat_out.sv
// Self-checking bench for cla8_sat_out; follows CLA8_IN_REG_EN for the expected latency.
module tb_cla8_sat_out;

`ifdef CLA8_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic signed [7:0] sum;
    logic              ovf;
    logic              uvf;

    int compared;
    int mismatched;

    cla8_sat_out dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .ovf   (ovf),
        .uvf   (uvf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operand pair and waits until its result is registered.
    task automatic run_vec(input logic signed [7:0] va, input logic signed [7:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a = 8'sd5;
        b = 8'sd5;
        #2;
        compared++;
        if (sum !== 8'sd0 || ovf !== 1'b0 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_init: got sum=%0d ovf=%b uvf=%b, want 0/0/0", sum, ovf, uvf);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            compared++;
            if (sum !== 8'sd0 || ovf !== 1'b0 || uvf !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_hold%0d: got sum=%0d ovf=%b uvf=%b, want 0/0/0", i, sum, ovf, uvf);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        compared++;
        if (sum !== 8'sd10 || ovf !== 1'b0 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release: got sum=%0d ovf=%b uvf=%b, want 10/0/0", sum, ovf, uvf);
        end
        // Asynchronous assertion between edges must clear the outputs immediately.
        run_vec(8'sd127, 8'sd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (sum !== 8'sd0 || ovf !== 1'b0 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_async: got sum=%0d ovf=%b uvf=%b, want 0/0/0", sum, ovf, uvf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_overflow;
        run_vec(8'sd127, 8'sd1);
        compared++;
        if (sum !== 8'sd127 || ovf !== 1'b1 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovf_127p1: got sum=%0d ovf=%b uvf=%b, want 127/1/0", sum, ovf, uvf);
        end
        run_vec(8'sd127, 8'sd127);
        compared++;
        if (sum !== 8'sd127 || ovf !== 1'b1 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovf_127p127: got sum=%0d ovf=%b uvf=%b, want 127/1/0", sum, ovf, uvf);
        end
    endtask

    task automatic test_underflow;
        run_vec(-8'sd128, -8'sd1);
        compared++;
        if (sum !== -8'sd128 || ovf !== 1'b0 || uvf !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL uvf_m128m1: got sum=%0d ovf=%b uvf=%b, want -128/0/1", sum, ovf, uvf);
        end
        run_vec(-8'sd128, -8'sd128);
        compared++;
        if (sum !== -8'sd128 || ovf !== 1'b0 || uvf !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL uvf_m128m128: got sum=%0d ovf=%b uvf=%b, want -128/0/1", sum, ovf, uvf);
        end
    endtask

    task automatic test_normal;
        run_vec(8'sd50, 8'sd25);
        compared++;
        if (sum !== 8'sd75 || ovf !== 1'b0 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL add_50p25: got sum=%0d ovf=%b uvf=%b, want 75/0/0", sum, ovf, uvf);
        end
        run_vec(-8'sd40, 8'sd15);
        compared++;
        if (sum !== -8'sd25 || ovf !== 1'b0 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL add_m40p15: got sum=%0d ovf=%b uvf=%b, want -25/0/0", sum, ovf, uvf);
        end
        run_vec(-8'sd1, 8'sd1);
        compared++;
        if (sum !== 8'sd0 || ovf !== 1'b0 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL add_m1p1: got sum=%0d ovf=%b uvf=%b, want 0/0/0", sum, ovf, uvf);
        end
        run_vec(8'sd15, 8'sd1);
        compared++;
        if (sum !== 8'sd16 || ovf !== 1'b0 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL add_15p1: got sum=%0d ovf=%b uvf=%b, want 16/0/0", sum, ovf, uvf);
        end
    endtask

    task automatic test_boundary;
        run_vec(8'sd126, 8'sd1);
        compared++;
        if (sum !== 8'sd127 || ovf !== 1'b0 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL edge_126p1: got sum=%0d ovf=%b uvf=%b, want 127/0/0", sum, ovf, uvf);
        end
        run_vec(-8'sd127, -8'sd1);
        compared++;
        if (sum !== -8'sd128 || ovf !== 1'b0 || uvf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL edge_m127m1: got sum=%0d ovf=%b uvf=%b, want -128/0/0", sum, ovf, uvf);
        end
    endtask

    // One new pair per cycle: overflow, normal, underflow, normal.
    task automatic test_back_to_back;
        logic signed [7:0] va   [4] = '{8'sd100, 8'sd10, -8'sd100, -8'sd3};
        logic signed [7:0] vb   [4] = '{8'sd100, 8'sd20, -8'sd100, 8'sd7};
        logic signed [7:0] esum [4] = '{8'sd127, 8'sd30, -8'sd128, 8'sd4};
        logic              eovf [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic              euvf [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4 + LAT - 1; i++) begin
            @(negedge clk);
            if (i < 4) begin
                a = va[i];
                b = vb[i];
            end
            @(posedge clk);
            #1;
            if (i >= LAT - 1) begin
                compared++;
                if (sum !== esum[i-LAT+1] || ovf !== eovf[i-LAT+1] || uvf !== euvf[i-LAT+1]) begin
                    mismatched++;
                    $display("[TB] FAIL b2b%0d: got sum=%0d ovf=%b uvf=%b, want %0d/%b/%b",
                             i - LAT + 1, sum, ovf, uvf, esum[i-LAT+1], eovf[i-LAT+1], euvf[i-LAT+1]);
                end
            end
        end
    endtask

    // Streams every operand pair against an integer saturating reference.
    task automatic test_exhaustive;
        logic [15:0]       pair;
        logic signed [7:0] ra;
        logic signed [7:0] rb;
        logic signed [7:0] esum;
        logic              eovf;
        logic              euvf;
        int                total;
        for (int i = 0; i < 65536 + LAT - 1; i++) begin
            @(negedge clk);
            if (i < 65536) begin
                pair = i[15:0];
                a = pair[15:8];
                b = pair[7:0];
            end
            @(posedge clk);
            #1;
            if (i >= LAT - 1) begin
                pair  = 16'(i - LAT + 1);
                ra    = pair[15:8];
                rb    = pair[7:0];
                total = int'(ra) + int'(rb);
                eovf  = (total > 127);
                euvf  = (total < -128);
                esum  = eovf ? 8'sd127 : (euvf ? -8'sd128 : 8'(total));
                compared++;
                if (sum !== esum || ovf !== eovf || uvf !== euvf) begin
                    mismatched++;
                    if (mismatched < 20)
                        $display("[TB] FAIL sweep %0d+%0d: got sum=%0d ovf=%b uvf=%b, want %0d/%b/%b",
                                 ra, rb, sum, ovf, uvf, esum, eovf, euvf);
                end
                compared++;
                if ((ovf & uvf) !== 1'b0) begin
                    mismatched++;
                    if (mismatched < 20)
                        $display("[TB] FAIL flags_exclusive %0d+%0d: got ovf&uvf=%b, want 0", ra, rb, ovf & uvf);
                end
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_overflow();
        test_underflow();
        test_normal();
        test_boundary();
        test_back_to_back();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
